// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a single full-adder
// cell and a carry flip-flop. Operands enter LSB-first, one bit per clock.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid (and its data)
// until that edge; ready may not depend combinationally on valid.
//   - Input port  : in_valid / in_ready, data a, b, cin. in_ready is high only
//                   in IDLE; in_valid while busy is dropped, not queued.
//   - Output port : out_valid / out_ready, data sum, cout. sum/cout are
//                   registered and stay stable while out_valid is high, and
//                   keep the last result after out_valid falls.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    logic             w_fa_a;
    logic             w_fa_b;
    logic             w_fa_c;
    logic             w_fa_half;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    // Full-adder cell: two half adders plus an OR for the carry.
    always_comb begin
        w_fa_a    = r_a_sr[0];
        w_fa_b    = r_b_sr[0];
        w_fa_c    = r_carry;
        w_fa_half = w_fa_a ^ w_fa_b;
        w_fa_sum  = w_fa_half ^ w_fa_c;
        w_fa_cout = (w_fa_a & w_fa_b) | (w_fa_half & w_fa_c);
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
        // Written as a shift of the concatenation so it also holds for WIDTH=1.
        w_sum_next = WIDTH'({w_fa_sum, r_sum_sr} >> 1);
    end

    // Control/state decode visible to the outside world.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = r_out_valid;
        sum       = r_sum;
        cout      = r_cout;
        dbg_state = r_state;
    end

    // Sequencer: accept in IDLE, shift one bit per edge in ADD, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum_sr <= w_sum_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= w_fa_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and
// WIDTH=1. Expected results are a + b + cin computed with plain arithmetic.
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic [1:0] st8;
    logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;
    logic [1:0] st1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
        .busy(busy8), .dbg_state(st8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
        .busy(busy1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks (WIDTH=8 instance) ----------------
    task automatic wait_idle8();
        int n = 0;
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) check("idle_timeout", 33'(ir8), 33'd1);
    endtask

    // Present operands for one edge; returns at the negedge after acceptance.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_idle8();
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        exp_q.push_back(33'(a) + 33'(b) + 33'(c));
        @(negedge clk);
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic wait_result8(input string tag);
        int lat = 0;
        logic [32:0] exp;
        while (!ov8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 33'(lat), 33'd8);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check({tag, "_sum"}, {24'd0, cout8, sum8}, exp);
    endtask

    task automatic release8(input string tag);
        or8 = 1'b1;
        @(negedge clk);
        check({tag, "_ov_drop"}, 33'(ov8), 33'd0);
        check({tag, "_ir_back"}, 33'(ir8), 33'd1);
        or8 = 1'b0;
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic r);
        if (sel == 1) begin
            iv1 = v; a1 = a[0]; b1 = b[0]; cin1 = c; or1 = r;
        end else begin
            iv8 = v; a8 = a; b8 = b; cin8 = c; or8 = r;
        end
    endtask

    // Random traffic with random valid/ready on either instance.
    task automatic rand_stream(input int sel, input int n_ops, input string tag);
        int done = 0;
        int issued = 0;
        int n = 0;
        logic ov, ir, nv, nr, nc;
        logic [7:0] na, nb, mask;
        logic [32:0] obs, exp;
        mask = (sel == 1) ? 8'h01 : 8'hFF;
        exp_q.delete();
        while (done < n_ops && n < 30000) begin
            ov  = (sel == 1) ? ov1 : ov8;
            ir  = (sel == 1) ? ir1 : ir8;
            obs = (sel == 1) ? {31'd0, cout1, sum1} : {24'd0, cout8, sum8};
            nv  = ($urandom_range(3, 0) != 0) && (issued < n_ops);
            nr  = 1'($urandom_range(1, 0));
            na  = 8'($urandom) & mask;
            nb  = 8'($urandom) & mask;
            nc  = 1'($urandom);
            drive(sel, nv, na, nb, nc, nr);
            if (ir && nv) begin
                exp_q.push_back(33'(na) + 33'(nb) + 33'(nc));
                issued++;
            end
            if (ov && nr) begin
                if (exp_q.size() == 0) check({tag, "_unexpected"}, 33'd1, 33'd0);
                else begin
                    exp = exp_q.pop_front();
                    check({tag, "_sum"}, obs, exp);
                end
                done++;
            end
            @(negedge clk);
            n++;
        end
        drive(sel, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check({tag, "_count"}, 33'(done), 33'(n_ops));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc[$];
        int nres;
        logic [32:0] exp;

        rst_n = 1'b0;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        #12;
        check("rst_sum", 33'(sum8), 33'd0);
        check("rst_cout", 33'(cout8), 33'd0);
        check("rst_ov", 33'(ov8), 33'd0);
        check("rst_ir", 33'(ir8), 33'd1);
        check("rst_busy", 33'(busy8), 33'd0);
        check("rst_ir_w1", 33'(ir1), 33'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic additions
        accept8(8'h3C, 8'h0F, 1'b0);
        check("3c_busy", 33'(busy8), 33'd1);
        check("3c_ir", 33'(ir8), 33'd0);
        wait_result8("3c_0f");
        check("3c_0f_const", {24'd0, cout8, sum8}, 33'h04B);
        release8("3c_0f");

        accept8(8'hFF, 8'h01, 1'b0);
        wait_result8("ff_01");
        check("ff_01_const", {24'd0, cout8, sum8}, 33'h100);
        release8("ff_01");

        accept8(8'hFF, 8'hFF, 1'b1);
        wait_result8("ff_ff_1");
        check("ff_ff_1_const", {24'd0, cout8, sum8}, 33'h1FF);
        release8("ff_ff_1");

        // Backpressure in DONE, with an ignored in_valid pulse
        accept8(8'h55, 8'hAA, 1'b1);
        wait_result8("bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
            end
            @(negedge clk);
            iv8 = 1'b0;
            check("bp_hold_ov", 33'(ov8), 33'd1);
            check("bp_hold_sum", {24'd0, cout8, sum8}, 33'h100);
            check("bp_hold_ir", 33'(ir8), 33'd0);
        end
        release8("bp");
        check("bp_sum_kept", {24'd0, cout8, sum8}, 33'h100);
        @(negedge clk);
        check("bp_pulse_dropped", 33'(busy8), 33'd0);

        // Asynchronous reset in the middle of ADD
        accept8(8'h12, 8'h34, 1'b0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 33'(sum8), 33'd0);
        check("mid_rst_cout", 33'(cout8), 33'd0);
        check("mid_rst_ov", 33'(ov8), 33'd0);
        check("mid_rst_ir", 33'(ir8), 33'd1);
        check("mid_rst_busy", 33'(busy8), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept8(8'h01, 8'h01, 1'b0);
        wait_result8("post_rst");
        check("post_rst_const", {24'd0, cout8, sum8}, 33'h002);
        release8("post_rst");

        // Back-to-back with out_ready held high
        nres = 0;
        or8 = 1'b1;
        for (int n = 0; n < 100 && nres < 3; n++) begin
            if (ov8) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("b2b_sum", {24'd0, cout8, sum8}, exp);
                nres++;
            end
            if (ir8 && acc.size() < 3) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                iv8 = 1'b1;
                exp_q.push_back(33'(a8) + 33'(b8) + 33'(cin8));
                acc.push_back(int'(cyc));
            end else begin
                iv8 = 1'b0;
            end
            @(negedge clk);
        end
        or8 = 1'b0;
        iv8 = 1'b0;
        check("b2b_results", 33'(nres), 33'd3);
        if (acc.size() == 3) begin
            check("b2b_interval_1", 33'(acc[1] - acc[0]), 33'd10);
            check("b2b_interval_2", 33'(acc[2] - acc[1]), 33'd10);
        end else begin
            check("b2b_accepts", 33'(acc.size()), 33'd3);
        end
        @(negedge clk);

        // Random traffic on both widths
        rand_stream(8, 1000, "rand_w8");
        rand_stream(1, 1000, "rand_w1");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
